// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, special encodings and the fetch FSM state type.
package mips_pkg;

  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// bubble takes precedence over load and writes a NOP with valid cleared.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  load,
  input  logic                  bubble,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic [ADDR_WIDTH-1:0] pc_plus1,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc_plus1,
  output logic                  if_id_valid
);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      if_id_instr    <= DATA_WIDTH'(NOP_INSTR);
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
    end else if (bubble) begin
      if_id_instr    <= DATA_WIDTH'(NOP_INSTR);
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
    end else if (load) begin
      if_id_instr    <= instr;
      if_id_pc_plus1 <= pc_plus1;
      if_id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage.
// Holds the PC, drives the instruction memory and fills IF/ID; handles stall, redirect and halt.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = DATA_WIDTH'(mips_pkg::HALT_INSTR)
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump_en,
  input  logic [25:0]           jump_target,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc_plus1,
  output logic                  if_id_valid,
  output logic                  halted
);

  fetch_state_t          state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next, pc_plus1, redirect_target;
  logic                  redirect, load, bubble;
  logic                  unused_jump_bits;

  // J-type field is wider than the word address; only the low bits index memory.
  assign unused_jump_bits = ^jump_target[25:ADDR_WIDTH];

  assign pc_plus1        = pc + ADDR_WIDTH'(1);
  assign redirect        = branch_taken | jump_en;
  assign redirect_target = branch_taken ? branch_target : jump_target[ADDR_WIDTH-1:0];

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= FETCH;
    else          state <= state_next;
  end

  // Next state, next PC and IF/ID control; the older branch wins over a jump.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load       = 1'b0;
    bubble     = 1'b0;
    if (redirect) begin
      pc_next    = redirect_target;
      bubble     = 1'b1;
      state_next = FETCH;
    end else if (!stall) begin
      unique case (state)
        FETCH: begin
          load = 1'b1;
          if (imem_data == HALT_INSTR) state_next = HALTED;
          else                         pc_next    = pc_plus1;
        end
        HALTED: bubble = 1'b1;
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) pc <= RESET_PC;
    else          pc <= pc_next;
  end

  assign imem_addr = pc;
  assign halted    = (state == HALTED);

  if_id_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id_reg (
    .clk            (clk),
    .reset_b        (reset_b),
    .load           (load),
    .bubble         (bubble),
    .instr          (imem_data),
    .pc_plus1       (pc_plus1),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid)
  );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the MIPS core. It sits directly upstream of the 1024x32 instruction memory and holds the program counter (PC). It drives the memory's word read address, captures the returned instruction into the IF/ID pipeline register, and handles stall, branch/jump redirect and halt.

Parameters:
ADDR_WIDTH, 10, word-address width of the PC and instruction memory.
DATA_WIDTH, 32, instruction width.
RESET_PC, 0, word address the PC loads on reset.
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch.

Ports:
clk  input  1  rising-edge clock
reset_b  input  1  reset; asynchronous, active-low
stall  input  1  hazard unit holds the PC and IF/ID
branch_taken  input  1  branch resolved taken (from EX)
branch_target  input  ADDR_WIDTH  branch word address
jump_en  input  1  jump decoded (from ID)
jump_target  input  26  J-type target field
imem_addr  output  ADDR_WIDTH  read address to the instruction memory; equals the PC
imem_data  input  DATA_WIDTH  instruction from memory, combinational in the same cycle as imem_addr
if_id_instr  output  DATA_WIDTH  IF/ID instruction
if_id_pc_plus1  output  ADDR_WIDTH  IF/ID PC+1 (word address)
if_id_valid  output  1  IF/ID contents are a real instruction
halted  output  1  fetch is halted

Behaviour:
- Reset (reset_b low, asynchronous; takes effect immediately, also mid-operation):
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - if_id_instr = 0 (NOP), if_id_pc_plus1 = 0, if_id_valid = 0.
  - state = FETCH, halted = 0.
- All other updates happen on the rising clk edge.
- PC arithmetic: pc_plus1 = (pc + 1) mod 2^ADDR_WIDTH, so 1023 wraps to 0. No byte addressing; all addresses are word addresses.
- Jump target = jump_target[ADDR_WIDTH-1:0]; upper bits are ignored.
- Edge priority, highest first: branch_taken > jump_en > stall > normal. Branch beats jump because the branch is the older instruction.
- Redirect (branch_taken or jump_en, in any state, including while stall is high):
  - pc <= target.
  - IF/ID <= bubble: instr 0, valid 0, pc_plus1 0.
  - state <= FETCH, halted <= 0.
- Stall (no redirect): pc, IF/ID and state all hold.
- FSM states: FETCH and HALTED.
- FETCH, normal edge:
  - IF/ID <= {imem_data, pc_plus1, valid 1}.
  - If imem_data == HALT_INSTR: pc holds, state <= HALTED, halted <= 1. The halt instruction itself is still passed to IF/ID with valid 1.
  - Otherwise pc <= pc_plus1.
- HALTED, normal edge:
  - pc holds.
  - IF/ID <= bubble (valid 0).
  - Leaves HALTED only on redirect or reset.
- Latency: the instruction at address A appears at the IF/ID outputs one clock after pc == A.
- imem_addr is driven straight from the pc register (no combinational path from inputs); it changes only on clk or reset.

Decomposition:
- Shared package mips_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - NOP_INSTR = 0 and HALT_INSTR.
  - Fetch state encoding: FETCH = 1'b0, HALTED = 1'b1.
- One sub-module, if_id_reg: the IF/ID pipeline register. Inputs are load, bubble, instr and pc_plus1; outputs are the three if_id_* signals. It uses the same asynchronous active-low reset.
- The PC, the FSM and the priority logic stay in fetch_unit.

Test Plan:
- Sequential fetch: release reset with memory[0..3] = 0x11,0x22,0x33,0x44 and no stall → imem_addr 0,1,2,3 on successive cycles; one cycle later if_id_instr = 0x11,0x22,0x33 with pc_plus1 = 1,2,3 and valid 1.
- Stall: hold stall high 2 cycles at pc = 2 → imem_addr stays 2 and IF/ID holds 0x22/pc_plus1 2 for both cycles; after release, fetch resumes at 2.
- Simultaneous redirect: branch_taken (target 0x100), jump_en (target field 0x3FF_0200) and stall all high on one edge → pc = 0x100, IF/ID valid 0, halted 0; with branch_taken low and jump_en high instead → pc = 0x200.
- Halt: memory[5] = 0xFFFFFFFF, fetch from 4 → IF/ID captures it with valid 1; pc stays 5 and halted = 1; following cycles give valid 0. A later branch to 0x010 clears halted and fetch resumes at 0x010.
- Wrap: jump to 0x3FF with memory[0x3FF] = 0xABCD → if_id_pc_plus1 = 0 and the next imem_addr = 0.
- Asynchronous reset mid-run: pull reset_b low between clock edges at pc = 7 → imem_addr = 0, valid = 0 and halted = 0 immediately, with no clock edge needed.
